// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// ----------------
// Hazard and flush controller for the in-order MIPS pipeline. A shift-register
// scoreboard tracks the instructions in flight from EX (entry 0) to WB
// (entry DEPTH-1). Each cycle the ID source registers are compared against the
// scoreboard to produce the stall, bubble, flush and forward-select controls
// for the IF/ID and ID/EX stage registers.
//
// Optional feature: define HAZARD_FWD_EN to enable forwarding. With it, only a
// load-use hazard on entry 0 stalls, and fwd_sel1/fwd_sel2 name the youngest
// matching entry. Without it, any match in the hazard window stalls and both
// selects are tied to 0.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   id_valid           ID stage holds a real instruction
//   id_src1/id_src2    rs/rt of the ID instruction
//   id_uses_src1/2     ID instruction reads rs/rt
//   id_dest, id_wb_en  destination and register-write enable of ID instruction
//   id_mem_read        ID instruction is a load
//   br_taken           branch resolved taken in EX this cycle
//   stall_out          hold PC and IF/ID
//   flush_if_id        clear IF/ID to a NOP
//   bubble_id_ex       load a NOP into ID/EX
//   fwd_sel1/fwd_sel2  0 = register file, k = result of scoreboard entry k-1
//   stall_cnt          saturating count of stall cycles
//   flush_cnt          saturating count of branch flushes
//
// All control outputs are combinational from the scoreboard and the ID inputs.
module pipe_hazard_unit #(
  parameter int REG_W     = 5,
  parameter int DEPTH     = 3,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_uses_src1,
  input  logic             id_uses_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             br_taken,
  output logic             stall_out,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Last scoreboard index that can still cause a hazard. When the register
  // file bypasses the WB write, the WB entry is excluded.
  localparam int WIN_LAST = DEPTH - 1 - RF_BYPASS;

  logic [DEPTH-1:0] sb_v;
  logic [DEPTH-1:0] sb_wb;
  logic [DEPTH-1:0] sb_mr;
  logic [REG_W-1:0] sb_dest [DEPTH];

  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             raw_stall;

  // Scoreboard shift register: entry 0 takes the ID instruction unless a
  // bubble is being inserted into ID/EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v  <= '0;
      sb_wb <= '0;
      sb_mr <= '0;
      for (int i = 0; i < DEPTH; i++) sb_dest[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        sb_v[i]    <= sb_v[i-1];
        sb_wb[i]   <= sb_wb[i-1];
        sb_mr[i]   <= sb_mr[i-1];
        sb_dest[i] <= sb_dest[i-1];
      end
      sb_v[0]    <= id_valid & ~bubble_id_ex;
      sb_wb[0]   <= id_wb_en;
      sb_mr[0]   <= id_mem_read;
      sb_dest[0] <= id_dest;
    end
  end

  // Per-entry source matches, restricted to the hazard window. Register 0 is
  // hard-wired to zero and never a dependency.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i <= WIN_LAST) begin
        match1[i] = id_valid & id_uses_src1 & sb_v[i] & sb_wb[i] &
                    (sb_dest[i] == id_src1) & (id_src1 != '0);
        match2[i] = id_valid & id_uses_src2 & sb_v[i] & sb_wb[i] &
                    (sb_dest[i] == id_src2) & (id_src2 != '0);
      end
    end
  end

`ifdef HAZARD_FWD_EN
  // Youngest producer wins: scan from the oldest entry down so the lowest
  // matching index is the last assignment.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match1[i]) fwd_sel1 = SEL_W'(i + 1);
      if (match2[i]) fwd_sel2 = SEL_W'(i + 1);
    end
  end

  // Only a load still in EX cannot be forwarded in time.
  assign raw_stall = (match1[0] | match2[0]) & sb_mr[0];
`else
  // Load flags are only needed to single out load-use hazards.
  logic unused_mr;
  assign unused_mr = ^sb_mr;

  assign fwd_sel1  = '0;
  assign fwd_sel2  = '0;
  assign raw_stall = (|match1) | (|match2);
`endif

  // A taken branch squashes the instruction in ID, so any stall it would
  // have caused is moot.
  assign stall_out    = raw_stall & ~br_taken;
  assign flush_if_id  = br_taken;
  assign bubble_id_ex = br_taken | stall_out;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_out && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (br_taken  && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit (DEPTH = 3, RF_BYPASS = 1). Expectations adapt to
// whether HAZARD_FWD_EN is defined. A second instance with a 4-bit counter
// width exercises counter saturation.
module tb_pipe_hazard_unit;

  localparam int REG_W = 5;
  localparam int DEPTH = 3;
  localparam int CNT_W = 16;
  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int EW    = 3 + 2 * SEL_W;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] s1;
    logic [REG_W-1:0] s2;
    logic             u1;
    logic             u2;
    logic [REG_W-1:0] d;
    logic             wb;
    logic             mr;
    logic             br;
    logic [EW-1:0]    exp;
  } row_t;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_src1 = '0;
  logic [REG_W-1:0] id_src2 = '0;
  logic             id_uses_src1 = 1'b0;
  logic             id_uses_src2 = 1'b0;
  logic [REG_W-1:0] id_dest = '0;
  logic             id_wb_en = 1'b0;
  logic             id_mem_read = 1'b0;
  logic             br_taken = 1'b0;
  logic             stall_out, flush_if_id, bubble_id_ex;
  logic [SEL_W-1:0] fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             s_stall, s_flush, s_bubble;
  logic [SEL_W-1:0] s_fs1, s_fs2;
  logic [3:0]       s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_W(REG_W), .DEPTH(DEPTH), .RF_BYPASS(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall_out(stall_out), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_unit #(.REG_W(REG_W), .DEPTH(DEPTH), .RF_BYPASS(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall_out(s_stall), .flush_if_id(s_flush), .bubble_id_ex(s_bubble),
    .fwd_sel1(s_fs1), .fwd_sel2(s_fs2), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- helpers ----------------
  // Expected forward select: the spec value with forwarding, else 0.
  function automatic int fsx(input int k);
    return FWD ? k : 0;
  endfunction

  function automatic row_t mk(input int v, input int s1, input int s2, input int u1,
                              input int u2, input int d, input int wb, input int mr,
                              input int br, input int st, input int fl, input int bu,
                              input int f1, input int f2);
    row_t r;
    r.v   = v[0];
    r.s1  = REG_W'(s1);
    r.s2  = REG_W'(s2);
    r.u1  = u1[0];
    r.u2  = u2[0];
    r.d   = REG_W'(d);
    r.wb  = wb[0];
    r.mr  = mr[0];
    r.br  = br[0];
    r.exp = {st[0], fl[0], bu[0], SEL_W'(f1), SEL_W'(f2)};
    return r;
  endfunction

  function automatic logic [EW-1:0] ctl_now();
    return {stall_out, flush_if_id, bubble_id_ex, fwd_sel1, fwd_sel2};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_uses_src1 = 1'b0;
    id_uses_src2 = 1'b0; id_dest = '0; id_wb_en = 1'b0; id_mem_read = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic apply_row(input row_t r);
    id_valid = r.v; id_src1 = r.s1; id_src2 = r.s2; id_uses_src1 = r.u1;
    id_uses_src2 = r.u2; id_dest = r.d; id_wb_en = r.wb; id_mem_read = r.mr;
    br_taken = r.br;
    exp_q.push_back(r.exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EW-1:0] e;
    rst = 1'b1;
    apply_row(mk(1, 3, 3, 1, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if (ctl_now() !== e) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl_now(), e);
    end
    n_cmp++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
    n_cmp++;
    if (flush_cnt !== '0) begin
      n_fail++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt);
    end
  endtask

  task automatic test_alu_fwd();
    row_t rows[$];
    logic [EW-1:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));   // ADD r3,r1,r2
`ifdef HAZARD_FWD_EN
    rows.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0));   // SUB r4,r3,r5
    rows.push_back(mk(1, 3, 3, 1, 1, 7, 1, 0, 0, 0, 0, 0, 2, 2));   // AND r7,r3,r3
    rows.push_back(mk(1, 3, 3, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));   // ADD at WB: bypassed
`else
    rows.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 0, 1, 0, 0));
    rows.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 0, 1, 0, 0));
    rows.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 3, 3, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0));
`endif
    foreach (rows[i]) begin
      @(negedge clk);
      apply_row(rows[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (ctl_now() !== e) begin
        n_fail++; $display("FAIL alu_fwd step %0d: got %b want %b", i, ctl_now(), e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== CNT_W'(FWD ? 0 : 2)) begin
      n_fail++; $display("FAIL alu_fwd_stall_cnt: got %0d want %0d", stall_cnt, FWD ? 0 : 2);
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [EW-1:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0));   // LW r2,0(r1)
`ifdef HAZARD_FWD_EN
    rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 1, 0, 1, 1, 1));   // ADD r6,r2,r2
    rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 2, 2));
`else
    rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 1, 0, 1, 0, 0));
    rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 1, 0, 1, 0, 0));
    rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
`endif
    foreach (rows[i]) begin
      @(negedge clk);
      apply_row(rows[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (ctl_now() !== e) begin
        n_fail++; $display("FAIL load_use step %0d: got %b want %b", i, ctl_now(), e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== CNT_W'(FWD ? 1 : 2)) begin
      n_fail++; $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt, FWD ? 1 : 2);
    end
  endtask

  task automatic test_r0_imm();
    row_t rows[$];
    logic [EW-1:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));   // ADDI r0
    rows.push_back(mk(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));   // reads r0,r0
    rows.push_back(mk(1, 1, 1, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));   // ADD r8
    rows.push_back(mk(1, 1, 8, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));   // ADDI r9, rt=8 unused
    rows.push_back(mk(1, 1, 8, 1, 1, 10, 1, 0, 0,
                      FWD ? 0 : 1, 0, FWD ? 0 : 1, 0, fsx(2))); // OR r10,r1,r8
    rows.push_back(mk(0, 9, 9, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));   // invalid ID
    rows.push_back(mk(1, 1, 1, 1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0));  // no writeback
    rows.push_back(mk(1, 11, 11, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      apply_row(rows[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (ctl_now() !== e) begin
        n_fail++; $display("FAIL r0_imm step %0d: got %b want %b", i, ctl_now(), e);
      end
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [EW-1:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0));             // LW r2
    rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 1, 0, 1, 1, fsx(1), fsx(1)));   // branch
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      apply_row(rows[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (ctl_now() !== e) begin
        n_fail++; $display("FAIL branch step %0d: got %b want %b", i, ctl_now(), e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (flush_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL branch_flush_cnt: got %0d want 1", flush_cnt);
    end
    n_cmp++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL branch_stall_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_dual_src();
    row_t rows[$];
    logic [EW-1:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 10, 11, 1, 1, 12, 1, 0, 0,
                      FWD ? 0 : 1, 0, FWD ? 0 : 1, fsx(2), fsx(1)));
    rows.push_back(mk(1, 10, 11, 1, 1, 12, 1, 0, 0,
                      FWD ? 0 : 1, 0, FWD ? 0 : 1, 0, fsx(2)));
    rows.push_back(mk(1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 13, 13, 1, 1, 14, 1, 0, 0,
                      FWD ? 0 : 1, 0, FWD ? 0 : 1, fsx(1), fsx(1)));
    foreach (rows[i]) begin
      @(negedge clk);
      apply_row(rows[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (ctl_now() !== e) begin
        n_fail++; $display("FAIL dual_src step %0d: got %b want %b", i, ctl_now(), e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== CNT_W'(FWD ? 0 : 3)) begin
      n_fail++; $display("FAIL dual_src_stall_cnt: got %0d want %0d", stall_cnt, FWD ? 0 : 3);
    end
  endtask

  task automatic test_mid_reset();
    logic [EW-1:0] e;
    do_reset();
    @(negedge clk);
    apply_row(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0));
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if (ctl_now() !== e) begin
      n_fail++; $display("FAIL mid_reset_lw: got %b want %b", ctl_now(), e);
    end
    @(negedge clk);
    apply_row(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 1, 0, 1, fsx(1), fsx(1)));
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if (ctl_now() !== e) begin
      n_fail++; $display("FAIL mid_reset_stall: got %b want %b", ctl_now(), e);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply_row(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if (ctl_now() !== e) begin
      n_fail++; $display("FAIL mid_reset_clear: got %b want %b", ctl_now(), e);
    end
    n_cmp++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL mid_reset_stall_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  // A self-dependent load held in ID stalls repeatedly: every other cycle
  // with forwarding, two of every three cycles without.
  task automatic test_saturation();
    int exp_stalls;
    exp_stalls = FWD ? 20 : 26;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      id_valid = 1'b1; id_src1 = 5'd1; id_src2 = '0; id_uses_src1 = 1'b1;
      id_uses_src2 = 1'b0; id_dest = 5'd1; id_wb_en = 1'b1; id_mem_read = 1'b1;
      br_taken = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== CNT_W'(exp_stalls)) begin
      n_fail++; $display("FAIL sat_stall_cnt: got %0d want %0d", stall_cnt, exp_stalls);
    end
    n_cmp++;
    if (s_stall_cnt !== 4'hF) begin
      n_fail++; $display("FAIL sat_stall_hold: got %0h want f", s_stall_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      drive_idle();
      br_taken = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (flush_cnt !== CNT_W'(20)) begin
      n_fail++; $display("FAIL sat_flush_cnt: got %0d want 20", flush_cnt);
    end
    n_cmp++;
    if (s_flush_cnt !== 4'hF) begin
      n_fail++; $display("FAIL sat_flush_hold: got %0h want f", s_flush_cnt);
    end
    n_cmp++;
    if (s_stall_cnt !== 4'hF) begin
      n_fail++; $display("FAIL sat_stall_still: got %0h want f", s_stall_cnt);
    end
    drive_idle();
  endtask

  // ---------------- sequencing and report ----------------
  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_r0_imm();
    test_branch();
    test_dual_src();
    test_mid_reset();
    test_saturation();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_q_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and flush controller for the in-order MIPS pipeline.
- Keeps a shift-register scoreboard of the instructions in flight from EX through WB, with DEPTH entries.
- Compares the ID-stage source registers against the scoreboard and drives the stall, bubble, flush and forward-select controls for the IF/ID and ID/EX stage registers.
- Successor to the fixed 5-stage wiring: depth and register-address width are generic, with optional forwarding and saturating perf counters.

Parameters:
- REG_W, 5, register-address width.
- DEPTH, 3, number of scoreboard entries; entry 0 = EX, entry DEPTH-1 = WB.
- RF_BYPASS, 1, 1 = register file returns the WB write value in the same cycle, so entry DEPTH-1 never causes a hazard.
- CNT_W, 16, width of the perf counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1  in  REG_W  rs of the ID instruction.
- id_src2  in  REG_W  rt of the ID instruction.
- id_uses_src1  in  1  ID instruction reads rs.
- id_uses_src2  in  1  ID instruction reads rt; 0 for immediate forms.
- id_dest  in  REG_W  destination register of the ID instruction.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- br_taken  in  1  branch resolved taken in EX this cycle.
- stall_out  out  1  hold PC and the IF/ID register.
- flush_if_id  out  1  clear the IF/ID register to a NOP.
- bubble_id_ex  out  1  load a NOP (all enables 0) into ID/EX.
- fwd_sel1  out  $clog2(DEPTH+1)  rs source select; 0 = register file, k = result of scoreboard entry k-1.
- fwd_sel2  out  $clog2(DEPTH+1)  same, for rt.
- stall_cnt  out  CNT_W  count of stall cycles.
- flush_cnt  out  CNT_W  count of branch flushes.

Behaviour:
- Scoreboard entry fields: {v, dest, wb_en, mem_read}. Reset clears every v, and both counters go to 0.
- Every cycle the scoreboard shifts one place: entry i+1 <= entry i, and entry DEPTH-1 is discarded.
- Entry 0 loads the ID fields with v = id_valid, except when bubble_id_ex = 1, in which case entry 0 gets v = 0.
- Match rule for source s at entry i, for s in {src1, src2}: all of
  - uses_s = 1
  - id_valid = 1
  - v[i] = 1
  - wb_en[i] = 1
  - dest[i] == src
  - src != 0 (register 0 is never a hazard)
- Hazard window: entries 0 to DEPTH-1-RF_BYPASS.
- Forward-select rule: fwd_sel = (index of the youngest matching entry in the window) + 1. The lowest index wins. The value is 0 if there is no match.
- Stall rule: stall_out = 1 when any window entry matches, subject to the optional feature.
- While stalled: bubble_id_ex = 1, and the IF/ID register and PC hold.
- The stall persists combinationally until the producer leaves the window.
- Branch rule: br_taken = 1 forces flush_if_id = 1 and bubble_id_ex = 1, and forces stall_out = 0. Branch has priority over stall, because the stalled instruction is on the wrong path.
- All control outputs are combinational from the scoreboard and the ID inputs; there is zero latency.
- After reset, with br_taken = 0, every control output is 0.
- Counters:
  - stall_cnt increments on each cycle with stall_out = 1.
  - flush_cnt increments on each cycle with br_taken = 1.
  - Both saturate at all-ones and do not wrap.
- Reset mid-operation: the scoreboard is fully invalidated on the next edge, with no residual stalls. Counters clear.
- Simultaneous match on src1 and src2 at different entries: each select is resolved independently, and one stall is generated.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined:
  - Forwarding is active and fwd_sel1/fwd_sel2 follow the forward-select rule above.
  - stall_out = 1 only on a load-use hazard, i.e. a match at entry 0 with mem_read[0] = 1, giving exactly one stall cycle.
  - A load at entry 1 or later is forwarded.
- Undefined:
  - fwd_sel1 and fwd_sel2 are tied to 0.
  - Any match in the window stalls.
  - A dependent instruction stalls until its producer leaves the window (up to DEPTH-RF_BYPASS cycles).

Test Plan:
- Reset: hold rst for 2 cycles with id_valid = 1 -> all controls 0 and both counters 0 on release.
- ADD r3 then SUB r4,r3,r5 back-to-back, forwarding on -> stall_out = 0 and fwd_sel1 = 1; next cycle, an instruction reading r3 -> fwd_sel = 2.
- LW r2 then ADD r6,r2,r2, forwarding on -> exactly 1 stall cycle with bubble_id_ex = 1, then fwd_sel1 = fwd_sel2 = 2; stall_cnt = 1.
- Same sequence with forwarding off, DEPTH = 3, RF_BYPASS = 1 -> 2 stall cycles, then fwd_sel = 0.
- Producer writes r0 -> no stall and fwd_sel = 0; ADDI with id_uses_src2 = 0 and rt == dest of the producer -> no rt hazard.
- br_taken while a load-use stall is pending -> flush_if_id = 1, bubble_id_ex = 1, stall_out = 0, flush_cnt = 1. Also preload stall_cnt to the CNT_W saturation point -> it holds 0xFFFF.
